junction_sequencer: RTL and testbench
=====================================

# junction_sequencer

Sequences the robot's motors at maze junctions using the 3-bit direction code from the tone detector. Between junctions it passes line-follower steering through to the motors. At a junction it stops, waits for a decoded tone direction, drives clear of the junction, then executes a timed turn. It sits between the tone detector (`tdDir` source), the line-follower sensor logic and the motor drivers, and is the sole owner of the motor command outputs.

## Interface
Parameters:
- `CNT_W`, 32: width of the shared phase timer.
- `CLEAR_CYCLES`, 25_000_000: cycles driving forward to cross the junction.
- `TURN_CYCLES`, 50_000_000: cycles for a 90° left/right pivot.
- `BACK_CYCLES`, 100_000_000: cycles for a 180° pivot.
- `TIMEOUT_CYCLES`, 250_000_000: wait-for-tone limit (watchdog build only).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `td_dir`  in  3  tone direction: STOP=100, STRAIGHT=000, LEFT=001, RIGHT=010, BACK=011, FINISH=111.
- `junction`  in  1  line sensors report a junction; level-sensitive.
- `line_steer`  in  2  follower request: 00 forward, 01 veer left, 10 veer right, 11 stop.
- `motor_l`  out  2  left motor: 00 off, 01 forward, 10 reverse.
- `motor_r`  out  2  right motor, same encoding.
- `busy`  out  1  high in every state except FOLLOW and HALT.
- `finished`  out  1  high in HALT.
- `timeout_err`  out  1  sticky watchdog flag. Constant 0 when the watchdog is compiled out.

## Operation
- States: FOLLOW, WAIT_TONE, CLEAR, TURN, HALT.
- FOLLOW: motors come from `line_steer`.
  - 00 → both forward.
  - 01 → left off, right forward.
  - 10 → left forward, right off.
  - 11 → both off.
  - `td_dir`=FINISH → HALT (takes priority).
  - Otherwise `junction`=1 → WAIT_TONE.
- WAIT_TONE: both motors off.
  - `td_dir`=FINISH → HALT.
  - Any other non-STOP code is latched into `dir_q` → CLEAR.
  - STOP holds the state.
- CLEAR: both motors forward for CLEAR_CYCLES.
  - `dir_q`=STRAIGHT → FOLLOW.
  - Otherwise → TURN, loading TURN_CYCLES, or BACK_CYCLES for BACK.
- TURN:
  - LEFT: left reverse, right forward.
  - RIGHT and BACK: left forward, right reverse.
  - On timer expiry → FOLLOW.
- HALT: motors off, `finished`=1. Only `rst` leaves this state.
- `td_dir` and `junction` are ignored during CLEAR and TURN. A junction still asserted on return to FOLLOW is treated as a new junction.
- Phase timer: counts from 0 and expires when count = N−1, so a phase lasts exactly N cycles. A parameter value of 0 behaves as 1.

## Timing
- All outputs are registered. Motor outputs change one cycle after the state or input change that causes them.
- FOLLOW→WAIT_TONE: the state changes on the first edge with `junction`=1. Motors read off from the following cycle.
- Direction latch: `dir_q` captures `td_dir` on the same edge that enters CLEAR. Later changes to `td_dir`, including a return to STOP, are ignored.
- Tone detector hold: its direction output is held for about 1.2 s, which is far longer than a WAIT_TONE poll, so no ack is needed.
- Reset value of every output and `dir_q`: `motor_l`=00, `motor_r`=00, `busy`=0, `finished`=0, `timeout_err`=0, `dir_q`=STOP, state FOLLOW, timer 0.
- Reset asserted mid-turn or mid-clear: aborts the phase on that edge, with no completion of the phase.

## Configuration
- `JSEQ_WATCHDOG_EN` defined: WAIT_TONE counts cycles.
  - At TIMEOUT_CYCLES with no valid code: set `timeout_err`, load `dir_q`=BACK and enter CLEAR.
  - `timeout_err` stays set until `rst`.
- `JSEQ_WATCHDOG_EN` undefined: WAIT_TONE waits indefinitely and `timeout_err` is tied to 0.

## Structure
- Package `jseq_pkg` holds:
  - direction-code localparams, shared with the tone detector;
  - motor command codes;
  - the state enum.
- Sub-module `jseq_timer`: a loadable CNT_W up-counter with `load`, `limit` and a one-cycle `expire` output. It is reused by the watchdog.

## Test plan
- Tests use CLEAR=4, TURN=6, BACK=12 and TIMEOUT=20.
- `line_steer`=01 in FOLLOW → next cycle `motor_l`=00, `motor_r`=01, `busy`=0.
- `junction` pulse, then `td_dir`=LEFT after 3 cycles → motors off while waiting; forward for exactly 4 cycles; left=10/right=01 for exactly 6 cycles; back to FOLLOW.
- `td_dir`=BACK, then switched to STOP during CLEAR → the 12-cycle pivot still executes with left=01/right=10.
- `td_dir`=FINISH in FOLLOW → HALT. `finished`=1 and motors 00 persist through later `junction`/`td_dir` activity until `rst`.
- `rst` on the 3rd TURN cycle → next cycle: all outputs at reset values, state FOLLOW.
- With `JSEQ_WATCHDOG_EN`, `junction` and `td_dir`=STOP held → after 20 cycles `timeout_err`=1, then a 4-cycle clear and a 12-cycle pivot.

Source files
------------

// File: rtl/junction_sequencer_pkg.sv
// Shared definitions for the junction sequencer.
// - Direction codes (same encoding as the tone detector's td_dir output).
// - Motor command codes for the motor drivers.
// - Sequencer state enum.
// - Helper to turn a phase length N into the terminal count (N-1, 0 treated as 1).
package jseq_pkg;

  localparam logic [2:0] DIR_STRAIGHT = 3'b000;
  localparam logic [2:0] DIR_LEFT     = 3'b001;
  localparam logic [2:0] DIR_RIGHT    = 3'b010;
  localparam logic [2:0] DIR_BACK     = 3'b011;
  localparam logic [2:0] DIR_STOP     = 3'b100;
  localparam logic [2:0] DIR_FINISH   = 3'b111;

  localparam logic [1:0] MOT_OFF = 2'b00;
  localparam logic [1:0] MOT_FWD = 2'b01;
  localparam logic [1:0] MOT_REV = 2'b10;

  typedef enum logic [2:0] {
    ST_FOLLOW,
    ST_WAIT_TONE,
    ST_CLEAR,
    ST_TURN,
    ST_HALT
  } jseq_state_t;

  // A phase of N cycles ends when the counter reaches N-1; N=0 acts like N=1.
  function automatic int unsigned last_tick(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/junction_sequencer_if.sv
// Signal bundle between the junction sequencer and its surroundings.
// master : environment side (drives td_dir, junction, line_steer; reads motors/status)
// slave  : sequencer side   (reads the inputs; drives motor_l, motor_r, busy,
//          finished, timeout_err)
interface jseq_if;
  logic [2:0] td_dir;
  logic       junction;
  logic [1:0] line_steer;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic       busy;
  logic       finished;
  logic       timeout_err;

  modport master (
    output td_dir, junction, line_steer,
    input  motor_l, motor_r, busy, finished, timeout_err
  );

  modport slave (
    input  td_dir, junction, line_steer,
    output motor_l, motor_r, busy, finished, timeout_err
  );
endinterface

// File: rtl/junction_sequencer_timer.sv
// jseq_timer: loadable phase timer shared by CLEAR, TURN and the wait watchdog.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : restart counting from 0 towards limit
//   limit    : terminal count (phase length minus one)
//   expire   : high for the single cycle in which count == limit
module jseq_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_limit;
  logic             r_run;

  assign expire = r_run && (r_count == r_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_limit <= '0;
      r_run   <= 1'b0;
    end else if (load) begin
      r_count <= '0;
      r_limit <= limit;
      r_run   <= 1'b1;
    end else if (expire) begin
      r_run   <= 1'b0;
    end else if (r_run) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/junction_sequencer.sv
// junction_sequencer: owns the motor commands. Passes line-follower steering
// through between junctions; at a junction stops, waits for a tone direction,
// drives clear of the junction, then performs a timed pivot.
// Optional feature macro: JSEQ_WATCHDOG_EN (wait-for-tone timeout -> forced
// 180 degree pivot and sticky timeout_err).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (jseq_if.slave):
//     td_dir[2:0]   : tone direction code
//     junction      : junction seen by line sensors (level)
//     line_steer[1:0]: follower request
//     motor_l/r[1:0]: registered motor commands
//     busy          : registered, high outside FOLLOW/HALT
//     finished      : registered, high in HALT
//     timeout_err   : sticky watchdog flag (0 without the watchdog)
module junction_sequencer
  import jseq_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned CLEAR_CYCLES   = 25_000_000,
  parameter int unsigned TURN_CYCLES    = 50_000_000,
  parameter int unsigned BACK_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic   clk,
  input  logic   rst,
  jseq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM_CLEAR   = CNT_W'(last_tick(CLEAR_CYCLES));
  localparam logic [CNT_W-1:0] LIM_TURN    = CNT_W'(last_tick(TURN_CYCLES));
  localparam logic [CNT_W-1:0] LIM_BACK    = CNT_W'(last_tick(BACK_CYCLES));
  localparam logic [CNT_W-1:0] LIM_TIMEOUT = CNT_W'(last_tick(TIMEOUT_CYCLES));

  jseq_state_t      r_state;
  logic [2:0]       r_dir;
  logic [1:0]       r_motor_l;
  logic [1:0]       r_motor_r;
  logic             r_busy;
  logic             r_finished;

  logic             w_load;
  logic [CNT_W-1:0] w_limit;
  logic             w_expire;
  logic             w_finish;
  logic             w_code_valid;
  logic [1:0]       w_steer_l;
  logic [1:0]       w_steer_r;

  assign w_finish     = (bus.td_dir == DIR_FINISH);
  assign w_code_valid = (bus.td_dir != DIR_STOP) && !w_finish;

  always_comb begin
    w_steer_l = MOT_OFF;
    w_steer_r = MOT_OFF;
    case (bus.line_steer)
      2'b00:   begin w_steer_l = MOT_FWD; w_steer_r = MOT_FWD; end
      2'b01:   begin w_steer_l = MOT_OFF; w_steer_r = MOT_FWD; end
      2'b10:   begin w_steer_l = MOT_FWD; w_steer_r = MOT_OFF; end
      default: begin w_steer_l = MOT_OFF; w_steer_r = MOT_OFF; end
    endcase
  end

  // Timer loads mirror the FSM transitions below. The timer also runs through
  // WAIT_TONE in every build; only the watchdog build reacts to its expiry there.
  always_comb begin
    w_load  = 1'b0;
    w_limit = LIM_CLEAR;
    case (r_state)
      ST_FOLLOW: begin
        if (!w_finish && bus.junction) begin
          w_load  = 1'b1;
          w_limit = LIM_TIMEOUT;
        end
      end
      ST_WAIT_TONE: begin
        if (w_code_valid) begin
          w_load  = 1'b1;
          w_limit = LIM_CLEAR;
        end
`ifdef JSEQ_WATCHDOG_EN
        else if (!w_finish && w_expire) begin
          w_load  = 1'b1;
          w_limit = LIM_CLEAR;
        end
`endif
      end
      ST_CLEAR: begin
        if (w_expire && (r_dir != DIR_STRAIGHT)) begin
          w_load  = 1'b1;
          w_limit = (r_dir == DIR_BACK) ? LIM_BACK : LIM_TURN;
        end
      end
      default: ;
    endcase
  end

  jseq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .limit  (w_limit),
    .expire (w_expire)
  );

`ifdef JSEQ_WATCHDOG_EN
  logic r_timeout;
`endif

  // Outputs are assigned together with the state they belong to, so they
  // always describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FOLLOW;
      r_dir      <= DIR_STOP;
      r_motor_l  <= MOT_OFF;
      r_motor_r  <= MOT_OFF;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
`ifdef JSEQ_WATCHDOG_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FOLLOW: begin
          if (w_finish) begin
            r_state    <= ST_HALT;
            r_motor_l  <= MOT_OFF;
            r_motor_r  <= MOT_OFF;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else if (bus.junction) begin
            r_state   <= ST_WAIT_TONE;
            r_motor_l <= MOT_OFF;
            r_motor_r <= MOT_OFF;
            r_busy    <= 1'b1;
          end else begin
            r_motor_l <= w_steer_l;
            r_motor_r <= w_steer_r;
          end
        end
        ST_WAIT_TONE: begin
          if (w_finish) begin
            r_state    <= ST_HALT;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end else if (w_code_valid) begin
            r_state   <= ST_CLEAR;
            r_dir     <= bus.td_dir;
            r_motor_l <= MOT_FWD;
            r_motor_r <= MOT_FWD;
          end
`ifdef JSEQ_WATCHDOG_EN
          else if (w_expire) begin
            r_state   <= ST_CLEAR;
            r_dir     <= DIR_BACK;
            r_timeout <= 1'b1;
            r_motor_l <= MOT_FWD;
            r_motor_r <= MOT_FWD;
          end
`endif
        end
        ST_CLEAR: begin
          if (w_expire) begin
            if (r_dir == DIR_STRAIGHT) begin
              r_state   <= ST_FOLLOW;
              r_busy    <= 1'b0;
              r_motor_l <= w_steer_l;
              r_motor_r <= w_steer_r;
            end else begin
              r_state <= ST_TURN;
              if (r_dir == DIR_LEFT) begin
                r_motor_l <= MOT_REV;
                r_motor_r <= MOT_FWD;
              end else begin
                r_motor_l <= MOT_FWD;
                r_motor_r <= MOT_REV;
              end
            end
          end
        end
        ST_TURN: begin
          if (w_expire) begin
            r_state   <= ST_FOLLOW;
            r_busy    <= 1'b0;
            r_motor_l <= w_steer_l;
            r_motor_r <= w_steer_r;
          end
        end
        ST_HALT: ;
        default: r_state <= ST_FOLLOW;
      endcase
    end
  end

  assign bus.motor_l  = r_motor_l;
  assign bus.motor_r  = r_motor_r;
  assign bus.busy     = r_busy;
  assign bus.finished = r_finished;
`ifdef JSEQ_WATCHDOG_EN
  assign bus.timeout_err = r_timeout;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_junction_sequencer.sv
// Testbench for junction_sequencer with CLEAR=4, TURN=6, BACK=12, TIMEOUT=20.
// Each cycle the expected output vector {timeout_err, finished, busy, motor_l,
// motor_r} is queued as stimulus is driven, then popped and compared #1 after
// the next rising edge.
module tb_junction_sequencer;
  import jseq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jseq_if bus ();

  junction_sequencer #(
    .CNT_W          (32),
    .CLEAR_CYCLES   (4),
    .TURN_CYCLES    (6),
    .BACK_CYCLES    (12),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic       exp_to = 1'b0;
  logic [6:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {to,fin,busy,l,r}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input string tag, input logic [1:0] l, input logic [1:0] r,
                     input logic busy, input logic fin);
    logic [6:0] exp;
    sb_q.push_back({exp_to, fin, busy, l, r});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_eq(tag, {bus.timeout_err, bus.finished, bus.busy, bus.motor_l, bus.motor_r}, exp);
  endtask

  task automatic cycn(input string tag, input int unsigned n, input logic [1:0] l,
                      input logic [1:0] r, input logic busy, input logic fin);
    for (int unsigned i = 0; i < n; i++) cyc(tag, l, r, busy, fin);
  endtask

  initial begin
    bus.td_dir     = DIR_STOP;
    bus.junction   = 1'b0;
    bus.line_steer = 2'b00;

    // Reset values
    rst = 1'b1;
    cycn("reset", 2, MOT_OFF, MOT_OFF, 1'b0, 1'b0);
    rst = 1'b0;

    // Steering pass-through in FOLLOW
    bus.line_steer = 2'b01; cyc("steer01", MOT_OFF, MOT_FWD, 1'b0, 1'b0);
    bus.line_steer = 2'b10; cyc("steer10", MOT_FWD, MOT_OFF, 1'b0, 1'b0);
    bus.line_steer = 2'b11; cyc("steer11", MOT_OFF, MOT_OFF, 1'b0, 1'b0);
    bus.line_steer = 2'b00; cyc("steer00", MOT_FWD, MOT_FWD, 1'b0, 1'b0);

    // LEFT: wait 3 cycles, clear 4, pivot 6, back to FOLLOW
    bus.junction = 1'b1;
    cyc("left_wait", MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    cycn("left_wait", 2, MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.td_dir = DIR_LEFT;
    cyc("left_clear", MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    bus.td_dir = DIR_STOP;
    cycn("left_clear", 3, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cycn("left_turn", 6, MOT_REV, MOT_FWD, 1'b1, 1'b0);
    cyc("left_follow", MOT_FWD, MOT_FWD, 1'b0, 1'b0);

    // BACK latched, td_dir returns to STOP during clear; 12-cycle pivot
    bus.junction = 1'b1;
    cyc("back_wait", MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    bus.td_dir = DIR_BACK;
    cyc("back_clear", MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    bus.td_dir = DIR_STOP;
    cycn("back_clear", 3, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cycn("back_turn", 12, MOT_FWD, MOT_REV, 1'b1, 1'b0);
    cyc("back_follow", MOT_FWD, MOT_FWD, 1'b0, 1'b0);

    // STRAIGHT with junction held: re-junction on return, then RIGHT
    bus.line_steer = 2'b01;
    bus.td_dir = DIR_STRAIGHT;
    bus.junction = 1'b1;
    cyc("str_wait", MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    cyc("str_clear", MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    bus.td_dir = DIR_STOP;
    cycn("str_clear", 3, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cyc("str_follow", MOT_OFF, MOT_FWD, 1'b0, 1'b0);
    cyc("rejunction", MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    bus.td_dir = DIR_RIGHT;
    cyc("right_clear", MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    bus.td_dir = DIR_STOP;
    cycn("right_clear", 3, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cycn("right_turn", 6, MOT_FWD, MOT_REV, 1'b1, 1'b0);
    cyc("right_follow", MOT_OFF, MOT_FWD, 1'b0, 1'b0);
    bus.line_steer = 2'b00;

    // Reset on the 3rd TURN cycle aborts the pivot
    bus.junction = 1'b1;
    cyc("rst_wait", MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    bus.td_dir = DIR_LEFT;
    cyc("rst_clear", MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    bus.td_dir = DIR_STOP;
    cycn("rst_clear", 3, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cycn("rst_turn", 2, MOT_REV, MOT_FWD, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("rst_mid_turn", MOT_OFF, MOT_OFF, 1'b0, 1'b0);
    rst = 1'b0;
    cycn("rst_follow", 3, MOT_FWD, MOT_FWD, 1'b0, 1'b0);

    // Long wait with STOP held
    bus.junction = 1'b1;
`ifdef JSEQ_WATCHDOG_EN
    cycn("wd_wait", 20, MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    exp_to = 1'b1;
    cycn("wd_clear", 4, MOT_FWD, MOT_FWD, 1'b1, 1'b0);
    cycn("wd_pivot", 12, MOT_FWD, MOT_REV, 1'b1, 1'b0);
    cyc("wd_follow", MOT_FWD, MOT_FWD, 1'b0, 1'b0);
    cyc("wd_sticky", MOT_FWD, MOT_FWD, 1'b0, 1'b0);
    rst = 1'b1;
    exp_to = 1'b0;
    cyc("wd_rst", MOT_OFF, MOT_OFF, 1'b0, 1'b0);
`else
    cycn("long_wait", 25, MOT_OFF, MOT_OFF, 1'b1, 1'b0);
    bus.junction = 1'b0;
    rst = 1'b1;
    cyc("wait_rst", MOT_OFF, MOT_OFF, 1'b0, 1'b0);
`endif
    rst = 1'b0;

    // FINISH wins over junction; HALT holds until reset
    bus.td_dir = DIR_FINISH;
    bus.junction = 1'b1;
    cyc("halt", MOT_OFF, MOT_OFF, 1'b0, 1'b1);
    bus.td_dir = DIR_LEFT;
    cycn("halt_hold", 5, MOT_OFF, MOT_OFF, 1'b0, 1'b1);
    bus.td_dir = DIR_STOP;
    bus.junction = 1'b0;
    bus.line_steer = 2'b10;
    cycn("halt_hold2", 3, MOT_OFF, MOT_OFF, 1'b0, 1'b1);
    rst = 1'b1;
    cyc("halt_rst", MOT_OFF, MOT_OFF, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("after_halt", MOT_FWD, MOT_OFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
